// File: rtl/trace_capture.sv
// trace_capture: on-chip logic-analyzer style trace core.
//
// Samples a probe bus into a circular buffer. A programmable number of
// samples is kept from before a trigger. The remaining buffer slots are
// filled after the trigger. The whole window is then streamed out,
// oldest sample first.
//
// Ports:
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   probe_i            bus under observation
//   arm_i, abort_i     start a new capture / return to idle (abort wins)
//   trig_mask_i        bits taking part in the trigger compare
//   trig_value_i       trigger compare value
//   trig_mode_i        0 = level match, 1 = rising edge of the match
//   pre_count_i        pre-trigger samples to keep, latched at arm
//   rd_start_i         start streaming the buffer (only honoured in DONE)
//   rd_data_o          streamed sample
//   rd_valid_o         rd_data_o is valid
//   rd_ready_i         consumer accepts the sample
//   rd_last_o          marks the final sample of the stream
//   state_o            IDLE=0 PRE=1 WAIT=2 POST=3 DONE=4 READ=5
//   trig_pos_o         buffer address holding the trigger sample
module trace_capture #(
  parameter  int PROBE_W = 64,
  parameter  int DEPTH   = 256,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PROBE_W-1:0] probe_i,
  input  logic               arm_i,
  input  logic               abort_i,
  input  logic [PROBE_W-1:0] trig_mask_i,
  input  logic [PROBE_W-1:0] trig_value_i,
  input  logic               trig_mode_i,
  input  logic [AW-1:0]      pre_count_i,
  input  logic               rd_start_i,
  output logic [PROBE_W-1:0] rd_data_o,
  output logic               rd_valid_o,
  input  logic               rd_ready_i,
  output logic               rd_last_o,
  output logic [2:0]         state_o,
  output logic [AW-1:0]      trig_pos_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4,
    S_READ = 3'd5
  } state_t;

  localparam logic [AW-1:0] MAX_IDX    = AW'(DEPTH - 1);
  localparam logic [AW:0]   LAST_ISSUE = (AW + 1)'(DEPTH - 1);
  localparam logic [AW:0]   ISSUE_END  = (AW + 1)'(DEPTH);

  state_t state, state_n;

  logic [PROBE_W-1:0] mem [DEPTH];
  logic [PROBE_W-1:0] mem_q;

  logic [AW-1:0] wp;
  logic [AW-1:0] pc;
  logic [AW-1:0] fill_cnt;
  logic [AW-1:0] post_cnt;
  logic [AW-1:0] trig_pos;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   issue_cnt;

  logic match, match_q, hit, we, issue, pop;
  logic ram_v, ram_last;
  logic skid_v, skid_last;
  logic [PROBE_W-1:0] skid_data;

  assign match = ((probe_i ^ trig_value_i) & trig_mask_i) == '0;
  assign hit   = trig_mode_i ? (match & ~match_q) : match;
  assign we    = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  assign pop   = rd_valid_o & rd_ready_i;

  // A RAM read may be issued unless both the RAM output stage and the
  // skid entry are full and nothing leaves this cycle. In that case the
  // RAM result would overwrite an unconsumed sample.
  assign issue = (state == S_READ) && (issue_cnt != ISSUE_END) &&
                 !(skid_v && ram_v && !rd_ready_i);

  // The skid entry is always older than the RAM stage, so it is presented
  // first. Data is forced to zero when nothing is valid.
  assign rd_valid_o = skid_v | ram_v;
  assign rd_data_o  = skid_v ? skid_data : (ram_v ? mem_q : '0);
  assign rd_last_o  = skid_v ? skid_last : (ram_v & ram_last);
  assign state_o    = state;
  assign trig_pos_o = trig_pos;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic. Arm and abort apply in every state, and abort has
  // priority. PRE ignores the trigger, so the pre-trigger samples are
  // always genuine.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = S_IDLE;
      S_PRE:  if (fill_cnt == pc - AW'(1)) state_n = S_WAIT;
      S_WAIT: if (hit) state_n = (pc == MAX_IDX) ? S_DONE : S_POST;
      S_POST: if (post_cnt == AW'(1)) state_n = S_DONE;
      S_DONE: if (rd_start_i) state_n = S_READ;
      S_READ: if (pop && rd_last_o) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
    if (arm_i)   state_n = (pre_count_i == '0) ? S_WAIT : S_PRE;
    if (abort_i) state_n = S_IDLE;
  end

  // Capture bookkeeping: write pointer, pre/post counters, trigger
  // address and read address. pre_count_i is only AW bits wide, so it
  // never exceeds DEPTH-1 and needs no clamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp        <= '0;
      pc        <= '0;
      fill_cnt  <= '0;
      post_cnt  <= '0;
      trig_pos  <= '0;
      rd_addr   <= '0;
      issue_cnt <= '0;
      match_q   <= 1'b0;
    end else if (arm_i && !abort_i) begin
      pc       <= pre_count_i;
      wp       <= '0;
      fill_cnt <= '0;
      match_q  <= 1'b0;
    end else begin
      match_q <= match;
      if (we) wp <= wp + AW'(1);
      if (state == S_PRE) fill_cnt <= fill_cnt + AW'(1);
      if (state == S_WAIT && hit) begin
        trig_pos <= wp;
        post_cnt <= MAX_IDX - pc;
      end
      if (state == S_POST) post_cnt <= post_cnt - AW'(1);
      if (state == S_DONE && rd_start_i) begin
        rd_addr   <= trig_pos - pc;
        issue_cnt <= '0;
      end
      if (issue) begin
        rd_addr   <= rd_addr + AW'(1);
        issue_cnt <= issue_cnt + (AW + 1)'(1);
      end
    end
  end

  // Sample memory with a registered read port. It has no reset, so it
  // can map onto block RAM. Writes happen only while capturing. Reads
  // happen only in READ. The two never overlap.
  always_ff @(posedge clk) begin
    if (we)    mem[wp] <= probe_i;
    if (issue) mem_q   <= mem[rd_addr];
  end

  // Output stage: RAM output register plus a one-entry skid. On a stall,
  // the RAM sample moves into the skid, and the read just issued lands
  // behind it. When the consumer is ready again, the stream continues
  // without a bubble. Leaving READ discards both entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_v     <= 1'b0;
      ram_last  <= 1'b0;
      skid_v    <= 1'b0;
      skid_last <= 1'b0;
      skid_data <= '0;
    end else if (state_n != S_READ) begin
      ram_v     <= 1'b0;
      ram_last  <= 1'b0;
      skid_v    <= 1'b0;
      skid_last <= 1'b0;
    end else begin
      ram_v <= issue | (ram_v & skid_v & ~pop);
      if (issue) ram_last <= (issue_cnt == LAST_ISSUE);
      if (skid_v) begin
        if (pop) begin
          skid_v    <= ram_v;
          skid_data <= mem_q;
          skid_last <= ram_last;
        end
      end else if (ram_v && !pop) begin
        skid_v    <= 1'b1;
        skid_data <= mem_q;
        skid_last <= ram_last;
      end
    end
  end

endmodule
